// File: rtl/alien_formation_motion_if.sv
// Bundle between the edge-collision logic, the game controller and the
// alien formation motion block. "master" drives the control inputs and
// reads back the formation position; "slave" is the motion block itself.
interface alien_formation_motion_if #(
   parameter int POS_W  = 11,
   parameter int WAVE_W = 4
);
   logic                     startOfFrame;
   logic                     playGame;
   logic                     collision;
   logic [3:0]               HitEdgeCode;
   logic                     matrixDefeated;
   logic                     alienKilled;
   logic signed [POS_W-1:0]  topLeftX;
   logic signed [POS_W-1:0]  topLeftY;
   logic                     movingRight;
   logic                     alienReachedBottom;
   logic [WAVE_W-1:0]        waveLevel;
   logic [1:0]               motionState;

   modport master (
      output startOfFrame, playGame, collision, HitEdgeCode, matrixDefeated, alienKilled,
      input  topLeftX, topLeftY, movingRight, alienReachedBottom, waveLevel, motionState
   );

   modport slave (
      input  startOfFrame, playGame, collision, HitEdgeCode, matrixDefeated, alienKilled,
      output topLeftX, topLeftY, movingRight, alienReachedBottom, waveLevel, motionState
   );
endinterface

// File: rtl/alien_formation_motion.sv
// Alien formation motion controller: integrates a per-frame X speed in
// signed fixed point, descends for several frames on an accepted edge hit,
// raises a sticky landed flag and halts, and speeds up per wave level.
// Optional kill acceleration is compiled in with ALIEN_KILL_ACCEL_EN.
module alien_formation_motion #(
   parameter int POS_W           = 11,
   parameter int FRAC_BITS       = 6,
   parameter int INITIAL_X       = 32,
   parameter int INITIAL_Y       = 80,
   parameter int INITIAL_X_SPEED = 40,
   parameter int SPEED_STEP      = 50,
   parameter int MAX_X_SPEED     = 400,
   parameter int DROP_STEP       = 128,
   parameter int DROP_FRAMES     = 4,
   parameter int BOTTOM_Y        = 400,
   parameter int WAVE_W          = 4,
   parameter int KILL_STEP       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   alien_formation_motion_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MARCH = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic signed [31:0] INIT_FPX   = 32'(INITIAL_X * (2 ** FRAC_BITS));
   localparam logic signed [31:0] INIT_FPY   = 32'(INITIAL_Y * (2 ** FRAC_BITS));
   localparam logic signed [31:0] BASE_SPD   = 32'(INITIAL_X_SPEED);
   localparam logic signed [31:0] STEP_SPD   = 32'(SPEED_STEP);
   localparam logic signed [31:0] MAX_SPD    = 32'(MAX_X_SPEED);
   localparam logic signed [31:0] DROP_S     = 32'(DROP_STEP);
   localparam logic signed [31:0] BOTTOM_S   = 32'(BOTTOM_Y);
   // A zero-frame descent still spends one frame descending.
   localparam logic [15:0]        DROP_LOAD  = (DROP_FRAMES < 1) ? 16'd1 : 16'(DROP_FRAMES);

   logic [1:0]         state_q, state_d;
   logic signed [31:0] fpx_q, fpx_d;
   logic signed [31:0] fpy_q, fpy_d;
   logic               right_q, right_d;
   logic [WAVE_W-1:0]  wave_q, wave_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic               bottom_q, bottom_d;
   logic signed [31:0] mag_raw_s, mag_s, xspeed_s;
   logic               hit_left_s, hit_right_s;
`ifdef ALIEN_KILL_ACCEL_EN
   logic [15:0]        boost_q, boost_d;
`endif

   // Landed when the sliced Y pixel of a fixed-point Y is at or past the bottom line.
   function automatic logic reached_bottom(input logic signed [31:0] fpy);
      logic signed [POS_W-1:0] pix;
      pix = fpy[POS_W+FRAC_BITS-1:FRAC_BITS];
      return (32'(pix) >= BOTTOM_S);
   endfunction

   // Speed magnitude from wave level (plus kill boost), saturated, signed by direction.
   always_comb begin
      mag_raw_s = BASE_SPD + $signed({{(32-WAVE_W){1'b0}}, wave_q}) * STEP_SPD;
`ifdef ALIEN_KILL_ACCEL_EN
      mag_raw_s = mag_raw_s + $signed({16'd0, boost_q});
`endif
      if (mag_raw_s > MAX_SPD) begin
         mag_s = MAX_SPD;
      end else begin
         mag_s = mag_raw_s;
      end
      xspeed_s = right_q ? mag_s : -mag_s;
   end

   // An edge hit counts only toward the current direction; a double-edge code is ignored.
   always_comb begin
      hit_left_s  = bus.collision & bus.HitEdgeCode[3] & ~bus.HitEdgeCode[1] & ~right_q;
      hit_right_s = bus.collision & bus.HitEdgeCode[1] & ~bus.HitEdgeCode[3] &  right_q;
   end

   // Next-state: playGame=0 > matrixDefeated > edge hit > frame integration.
   always_comb begin
      state_d    = state_q;
      fpx_d      = fpx_q;
      fpy_d      = fpy_q;
      right_d    = right_q;
      wave_d     = wave_q;
      drop_cnt_d = drop_cnt_q;
      bottom_d   = bottom_q;
`ifdef ALIEN_KILL_ACCEL_EN
      boost_d    = bus.alienKilled ? boost_q + 16'(KILL_STEP) : boost_q;
`endif
      if (!bus.playGame) begin
         state_d    = ST_IDLE;
         fpx_d      = INIT_FPX;
         fpy_d      = INIT_FPY;
         right_d    = 1'b1;
         drop_cnt_d = 16'd0;
         bottom_d   = 1'b0;
`ifdef ALIEN_KILL_ACCEL_EN
         boost_d    = 16'd0;
`endif
      end else if ((state_q != ST_IDLE) && bus.matrixDefeated) begin
         if (wave_q != {WAVE_W{1'b1}}) begin
            wave_d = wave_q + WAVE_W'(1);
         end else begin
            wave_d = wave_q;
         end
         state_d    = ST_MARCH;
         fpx_d      = INIT_FPX;
         fpy_d      = INIT_FPY;
         right_d    = 1'b1;
         drop_cnt_d = 16'd0;
         bottom_d   = 1'b0;
`ifdef ALIEN_KILL_ACCEL_EN
         boost_d    = 16'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_MARCH;
            end
            ST_MARCH: begin
               if (hit_left_s || hit_right_s) begin
                  right_d    = ~right_q;
                  drop_cnt_d = DROP_LOAD;
                  state_d    = ST_DROP;
               end else if (bus.startOfFrame) begin
                  fpx_d = fpx_q + xspeed_s;
                  if (reached_bottom(fpy_q)) begin
                     bottom_d = 1'b1;
                     state_d  = ST_HALT;
                  end else begin
                     state_d  = ST_MARCH;
                  end
               end else begin
                  state_d = ST_MARCH;
               end
            end
            ST_DROP: begin
               if (bus.startOfFrame) begin
                  fpy_d = fpy_q + DROP_S;
                  if (reached_bottom(fpy_d)) begin
                     bottom_d = 1'b1;
                     state_d  = ST_HALT;
                  end else if (drop_cnt_q <= 16'd1) begin
                     drop_cnt_d = 16'd0;
                     state_d    = ST_MARCH;
                  end else begin
                     drop_cnt_d = drop_cnt_q - 16'd1;
                     state_d    = ST_DROP;
                  end
               end else begin
                  state_d = ST_DROP;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State registers with synchronous reset to the start position.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fpx_q      <= INIT_FPX;
         fpy_q      <= INIT_FPY;
         right_q    <= 1'b1;
         wave_q     <= {WAVE_W{1'b0}};
         drop_cnt_q <= 16'd0;
         bottom_q   <= 1'b0;
`ifdef ALIEN_KILL_ACCEL_EN
         boost_q    <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         fpx_q      <= fpx_d;
         fpy_q      <= fpy_d;
         right_q    <= right_d;
         wave_q     <= wave_d;
         drop_cnt_q <= drop_cnt_d;
         bottom_q   <= bottom_d;
`ifdef ALIEN_KILL_ACCEL_EN
         boost_q    <= boost_d;
`endif
      end
   end

   assign bus.topLeftX           = fpx_q[POS_W+FRAC_BITS-1:FRAC_BITS];
   assign bus.topLeftY           = fpy_q[POS_W+FRAC_BITS-1:FRAC_BITS];
   assign bus.movingRight        = right_q;
   assign bus.alienReachedBottom = bottom_q;
   assign bus.waveLevel          = wave_q;
   assign bus.motionState        = state_q;
endmodule

// File: tb/tb_alien_formation_motion.sv
// Bench for alien_formation_motion: two instances (default bottom line and a
// shallow bottom line of 84) share one stimulus stream; a frame-level model
// predicts every output each cycle, and a few literal values pin the model.
module tb_alien_formation_motion;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sof, play, col, def, kill;
   logic [3:0] code;

   alien_formation_motion_if #(.POS_W(11), .WAVE_W(4)) bus_a();
   alien_formation_motion_if #(.POS_W(11), .WAVE_W(4)) bus_b();

   assign bus_a.startOfFrame   = sof;
   assign bus_a.playGame       = play;
   assign bus_a.collision      = col;
   assign bus_a.HitEdgeCode    = code;
   assign bus_a.matrixDefeated = def;
   assign bus_a.alienKilled    = kill;
   assign bus_b.startOfFrame   = sof;
   assign bus_b.playGame       = play;
   assign bus_b.collision      = col;
   assign bus_b.HitEdgeCode    = code;
   assign bus_b.matrixDefeated = def;
   assign bus_b.alienKilled    = kill;

   alien_formation_motion dut_a (.clk(clk), .reset(rst), .bus(bus_a));
   alien_formation_motion #(.BOTTOM_Y(84)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Frame-level model: pixel-independent fixed-point position plus a few flags.
   logic signed [31:0] m_x [2];
   logic signed [31:0] m_y [2];
   bit                 m_right [2];
   bit                 m_active [2];
   bit                 m_landed [2];
   int                 m_wave [2];
   int                 m_drop [2];
   int                 bottom [2] = '{400, 84};

   function automatic bit landed_at(input logic signed [31:0] y, input int b);
      logic signed [10:0] py;
      py = y[16:6];
      return (int'(py) >= b);
   endfunction

   task automatic home(input int k);
      m_x[k] = 32'sd2048;
      m_y[k] = 32'sd5120;
      m_right[k] = 1'b1;
      m_drop[k] = 0;
      m_landed[k] = 1'b0;
   endtask

   task automatic model_step();
      int mag;
      bit hit;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            home(k);
            m_wave[k] = 0;
            m_active[k] = 1'b0;
         end else if (!play) begin
            home(k);
            m_active[k] = 1'b0;
         end else if (!m_active[k]) begin
            m_active[k] = 1'b1;
         end else if (def) begin
            m_wave[k] = (m_wave[k] < 15) ? m_wave[k] + 1 : 15;
            home(k);
         end else if (m_landed[k]) begin
            m_landed[k] = 1'b1;
         end else if (m_drop[k] > 0) begin
            if (sof) begin
               m_y[k] = m_y[k] + 32'sd128;
               m_drop[k] = m_drop[k] - 1;
               if (landed_at(m_y[k], bottom[k])) m_landed[k] = 1'b1;
            end
         end else begin
            hit = col && (code[3] != code[1]) && (code[3] ? !m_right[k] : m_right[k]);
            mag = 40 + m_wave[k] * 50;
            if (mag > 400) mag = 400;
            if (hit) begin
               m_right[k] = !m_right[k];
               m_drop[k] = 4;
            end else if (sof) begin
               m_x[k] = m_x[k] + (m_right[k] ? mag : -mag);
               if (landed_at(m_y[k], bottom[k])) m_landed[k] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_state(input int k);
      if (!m_active[k]) return 32'd0;
      if (m_landed[k]) return 32'd3;
      if (m_drop[k] > 0) return 32'd2;
      return 32'd1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cmp_unit(input int k, input logic [1:0] st, input logic [10:0] tx,
                           input logic [10:0] ty, input logic mr, input logic rb,
                           input logic [3:0] wv);
      logic [31:0] xv, yv;
      xv = m_x[k];
      yv = m_y[k];
      check($sformatf("u%0d_state", k), {30'd0, st}, exp_state(k));
      check($sformatf("u%0d_x", k), {21'd0, tx}, {21'd0, xv[16:6]});
      check($sformatf("u%0d_y", k), {21'd0, ty}, {21'd0, yv[16:6]});
      check($sformatf("u%0d_right", k), {31'd0, mr}, {31'd0, m_right[k]});
      check($sformatf("u%0d_bottom", k), {31'd0, rb}, {31'd0, m_landed[k]});
      check($sformatf("u%0d_wave", k), {28'd0, wv}, 32'(m_wave[k]));
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_unit(0, bus_a.motionState, bus_a.topLeftX, bus_a.topLeftY,
                  bus_a.movingRight, bus_a.alienReachedBottom, bus_a.waveLevel);
         cmp_unit(1, bus_b.motionState, bus_b.topLeftX, bus_b.topLeftY,
                  bus_b.movingRight, bus_b.alienReachedBottom, bus_b.waveLevel);
      end
   end

   task automatic cyc(input logic s, input logic p, input logic c, input logic [3:0] h,
                      input logic d, input logic r);
      sof = s; play = p; col = c; code = h; def = d; rst = r;
      kill = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
      chk_en = 1'b1;
      check("rst_state", {30'd0, bus_a.motionState}, 32'd0);
      check("rst_x", 32'(bus_a.topLeftX), 32'd32);
      check("rst_y", 32'(bus_a.topLeftY), 32'd80);

      cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("start_march", {30'd0, bus_a.motionState}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      end
      check("ten_frames_x", 32'(bus_a.topLeftX), 32'd38);
      check("ten_frames_y", 32'(bus_a.topLeftY), 32'd80);

      // Left-edge hit while marching right is ignored.
      cyc(1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
      check("left_ign_dir", {31'd0, bus_a.movingRight}, 32'd1);
      check("left_ign_state", {30'd0, bus_a.motionState}, 32'd1);

      // Right-edge hit: turn and descend; frame in same cycle not integrated.
      cyc(1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
      check("hit_dir", {31'd0, bus_a.movingRight}, 32'd0);
      check("hit_state", {30'd0, bus_a.motionState}, 32'd2);
      cyc(1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
      check("drop_hit_ign", {31'd0, bus_a.movingRight}, 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
      check("b_land_state", {30'd0, bus_b.motionState}, 32'd3);
      check("b_land_flag", {31'd0, bus_b.alienReachedBottom}, 32'd1);
      check("b_land_y", 32'(bus_b.topLeftY), 32'd84);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("drop_done_y", 32'(bus_a.topLeftY), 32'd88);
      check("drop_done_st", {30'd0, bus_a.motionState}, 32'd1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
      check("b_halt_y", 32'(bus_b.topLeftY), 32'd84);
      check("b_halt_x", 32'(bus_b.topLeftX), 32'd38);

      cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
      check("def_wave", {28'd0, bus_b.waveLevel}, 32'd1);
      check("def_x", 32'(bus_b.topLeftX), 32'd32);
      check("def_y", 32'(bus_b.topLeftY), 32'd80);
      check("def_state", {30'd0, bus_b.motionState}, 32'd1);
      check("def_flag", {31'd0, bus_b.alienReachedBottom}, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("wave1_x", 32'(bus_b.topLeftX), 32'd33);

      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) != 0),
             1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 499) == 0));
      end

      cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
      check("sat_wave", {28'd0, bus_a.waveLevel}, 32'd15);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("sat_speed_x", 32'(bus_a.topLeftX), 32'd38);
      cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
      check("sat_wave_hold", {28'd0, bus_a.waveLevel}, 32'd15);

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
